sonata_sw_debounce: RTL and testbench

- Debounce and edge-detect stage for the Sonata navigation and user switches.
- Sits between the top-level switch pads and the demo system's general-purpose input bus.
- Input is the polarity-corrected switch vector: 1 = pressed or on.
- Synchronises each bit into clk_sys_i, filters contact bounce with a shared sample prescaler, and presents a stable level plus one-cycle rise/fall pulses.

---
 rtl/sonata_sw_debounce_pkg.sv | 20 ++
 rtl/sonata_sw_debounce_bit.sv | 85 ++++++++
 rtl/sonata_sw_debounce.sv | 79 +++++++
 tb/tb_sonata_sw_debounce.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonata_sw_debounce_pkg.sv
// Shared widths, 50 MHz timing defaults and the switch vector type
// for the Sonata switch debounce stage.
package sonata_sw_pkg;

   localparam int NavSwWidth  = 5;
   localparam int UserSwWidth = 8;
   localparam int SwWidth     = NavSwWidth + UserSwWidth;

   // 1 ms sample tick at 50 MHz, 10 ms of stable level to accept
   localparam int DefTickCycles  = 50000;
   localparam int DefStableTicks = 10;
   localparam int DefSyncStages  = 2;

   typedef logic [SwWidth-1:0] sw_vec_t;

   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sonata_sw_debounce_bit.sv
// One switch bit: synchroniser, stable-tick counter, level flop
// and registered rise/fall pulses.
module sonata_sw_debounce_bit
   import sonata_sw_pkg::*;
#(
   parameter int StableTicks = DefStableTicks,
   parameter int SyncStages  = DefSyncStages
) (
   input  logic clk_sys_i,
   input  logic rst_sys_ni,
   input  logic sw_i,
   input  logic tick_i,
   output logic sw_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CntW = cnt_width(StableTicks + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(StableTicks - 1);

   logic [SyncStages-1:0] sync_q;
   logic                  sync;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  sw_q, sw_d;
   logic                  rise_q, rise_d;
   logic                  fall_q, fall_d;
   logic                  same;
   logic                  done;

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SyncStages-2:0], sw_i};
      end
   end

   assign sync = sync_q[SyncStages-1];
   assign same = (sync == sw_q);
   assign done = (cnt_q == CntMax);

   always_comb begin
      cnt_d  = cnt_q;
      sw_d   = sw_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      unique case (1'b1)
         !tick_i: begin
         end
         tick_i && same: begin
            cnt_d = '0;
         end
         tick_i && !same && done: begin
            sw_d   = sync;
            cnt_d  = '0;
            rise_d = sync;
            fall_d = ~sync;
         end
         tick_i && !same && !done: begin
            cnt_d = cnt_q + 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         cnt_q  <= '0;
         sw_q   <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sw_q   <= sw_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign sw_o   = sw_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/sonata_sw_debounce.sv
// Sonata switch debounce: shared prescaler, per-bit filters, and an
// optional sticky change irq enabled by SONATA_SW_DEBOUNCE_IRQ_EN.
module sonata_sw_debounce
   import sonata_sw_pkg::*;
#(
   parameter int Width       = SwWidth,
   parameter int TickCycles  = DefTickCycles,
   parameter int StableTicks = DefStableTicks,
   parameter int SyncStages  = DefSyncStages
) (
   input  logic             clk_sys_i,
   input  logic             rst_sys_ni,
   input  logic [Width-1:0] sw_i,
   output logic [Width-1:0] sw_o,
   output logic [Width-1:0] rise_o,
   output logic [Width-1:0] fall_o,
   output logic             irq_o,
   input  logic             irq_clr_i
);

   localparam int PreW = cnt_width(TickCycles);
   localparam logic [PreW-1:0] PreMax = PreW'(TickCycles - 1);

   logic [PreW-1:0] pre_q;
   logic            tick;

   assign tick = (pre_q == PreMax);

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         pre_q <= '0;
      end else if (tick) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_q + 1'b1;
      end
   end

   for (genvar i = 0; i < Width; i++) begin : g_bit
      sonata_sw_debounce_bit #(
         .StableTicks (StableTicks),
         .SyncStages  (SyncStages)
      ) u_bit (
         .clk_sys_i  (clk_sys_i),
         .rst_sys_ni (rst_sys_ni),
         .sw_i       (sw_i[i]),
         .tick_i     (tick),
         .sw_o       (sw_o[i]),
         .rise_o     (rise_o[i]),
         .fall_o     (fall_o[i])
      );
   end

`ifdef SONATA_SW_DEBOUNCE_IRQ_EN
   logic irq_q;
   logic any_edge;

   assign any_edge = |{rise_o, fall_o};

   // a new pulse takes priority over a coincident clear
   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         irq_q <= 1'b0;
      end else if (any_edge) begin
         irq_q <= 1'b1;
      end else if (irq_clr_i) begin
         irq_q <= 1'b0;
      end
   end

   assign irq_o = irq_q;
`else
   logic unused_irq_clr;

   assign unused_irq_clr = irq_clr_i;
   assign irq_o          = 1'b0;
`endif

endmodule

// File: tb/tb_sonata_sw_debounce.sv
// Directed bench for sonata_sw_debounce with a fast tick
// (TickCycles=4, StableTicks=3, SyncStages=2).
module tb_sonata_sw_debounce;

`ifdef SONATA_SW_DEBOUNCE_IRQ_EN
   localparam logic IrqEn = 1'b1;
`else
   localparam logic IrqEn = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic [12:0] sw_i;
   logic [12:0] sw_o;
   logic [12:0] rise_o;
   logic [12:0] fall_o;
   logic        irq_o;
   logic        irq_clr;

   int checks;
   int errors;

   sonata_sw_debounce #(
      .Width       (13),
      .TickCycles  (4),
      .StableTicks (3),
      .SyncStages  (2)
   ) dut (
      .clk_sys_i  (clk),
      .rst_sys_ni (rst_n),
      .sw_i       (sw_i),
      .sw_o       (sw_o),
      .rise_o     (rise_o),
      .fall_o     (fall_o),
      .irq_o      (irq_o),
      .irq_clr_i  (irq_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // cycles until sw_o == want; returns max_cyc+1 on timeout
   task automatic wait_sw(input logic [12:0] want, input int max_cyc,
                          output int cyc);
      cyc = 0;
      do begin
         step();
         cyc++;
      end while (sw_o !== want && cyc <= max_cyc);
   endtask

   task automatic test_reset();
      int cyc;
      rst_n   = 1'b0;
      sw_i    = 13'h1FFF;
      irq_clr = 1'b0;
      repeat (3) step();
      checks++;
      if (sw_o !== 13'h0) begin
         errors++;
         $display("FAIL rst_sw got %h want %h", sw_o, 13'h0);
      end
      checks++;
      if (rise_o !== 13'h0 || fall_o !== 13'h0) begin
         errors++;
         $display("FAIL rst_pulse got %h/%h want 0/0", rise_o, fall_o);
      end
      checks++;
      if (irq_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_irq got %b want 0", irq_o);
      end
      rst_n = 1'b1;
      wait_sw(13'h1FFF, 14, cyc);
      checks++;
      if (cyc > 14) begin
         errors++;
         $display("FAIL rst_lat got %0d want <=14", cyc);
      end
      checks++;
      if (rise_o !== 13'h1FFF || fall_o !== 13'h0) begin
         errors++;
         $display("FAIL rst_rise got %h/%h want 1fff/0", rise_o, fall_o);
      end
      step();
      checks++;
      if (rise_o !== 13'h0 || sw_o !== 13'h1FFF) begin
         errors++;
         $display("FAIL rst_once got %h/%h want 0/1fff", rise_o, sw_o);
      end
      checks++;
      if (irq_o !== IrqEn) begin
         errors++;
         $display("FAIL rst_irqset got %b want %b", irq_o, IrqEn);
      end
   endtask

   task automatic test_release_all();
      int cyc;
      sw_i = 13'h0;
      wait_sw(13'h0, 14, cyc);
      checks++;
      if (cyc > 14) begin
         errors++;
         $display("FAIL rel_all_lat got %0d want <=14", cyc);
      end
      checks++;
      if (fall_o !== 13'h1FFF || rise_o !== 13'h0) begin
         errors++;
         $display("FAIL rel_all_fall got %h/%h want 1fff/0", fall_o, rise_o);
      end
   endtask

   task automatic test_clean_press();
      int cyc;
      sw_i = 13'h0001;
      wait_sw(13'h0001, 14, cyc);
      checks++;
      if (cyc < 11 || cyc > 14) begin
         errors++;
         $display("FAIL press_lat got %0d want 11..14", cyc);
      end
      checks++;
      if (rise_o !== 13'h0001 || fall_o !== 13'h0) begin
         errors++;
         $display("FAIL press_pulse got %h/%h want 0001/0", rise_o, fall_o);
      end
      step();
      checks++;
      if (rise_o !== 13'h0 || sw_o !== 13'h0001) begin
         errors++;
         $display("FAIL press_once got %h/%h want 0/0001", rise_o, sw_o);
      end
   endtask

   task automatic test_bounce();
      for (int t = 0; t < 80; t++) begin
         if (t < 60 && t % 5 == 0) sw_i[3] = ~sw_i[3];
         if (t == 60) sw_i[3] = 1'b0;
         step();
         checks++;
         if (sw_o !== 13'h0001 || rise_o !== 13'h0 || fall_o !== 13'h0) begin
            errors++;
            $display("FAIL bounce t=%0d got %h/%h/%h want 0001/0/0",
                     t, sw_o, rise_o, fall_o);
         end
      end
   endtask

   task automatic test_release();
      int cyc;
      sw_i = 13'h0021;
      wait_sw(13'h0021, 14, cyc);
      checks++;
      if (cyc > 14 || rise_o !== 13'h0020) begin
         errors++;
         $display("FAIL rel_setup got %0d/%h want <=14/0020", cyc, rise_o);
      end
      sw_i = 13'h0001;
      wait_sw(13'h0001, 14, cyc);
      checks++;
      if (cyc > 14) begin
         errors++;
         $display("FAIL rel_lat got %0d want <=14", cyc);
      end
      checks++;
      if (fall_o !== 13'h0020 || rise_o !== 13'h0) begin
         errors++;
         $display("FAIL rel_fall got %h/%h want 0020/0", fall_o, rise_o);
      end
      step();
      checks++;
      if (fall_o !== 13'h0) begin
         errors++;
         $display("FAIL rel_once got %h want 0", fall_o);
      end
   endtask

   task automatic test_simultaneous();
      int cyc;
      sw_i = 13'h0;
      wait_sw(13'h0, 14, cyc);
      checks++;
      if (cyc > 14) begin
         errors++;
         $display("FAIL simul_clr got %0d want <=14", cyc);
      end
      sw_i = 13'h0104;
      wait_sw(13'h0104, 14, cyc);
      checks++;
      if (cyc < 11 || cyc > 14) begin
         errors++;
         $display("FAIL simul_lat got %0d want 11..14", cyc);
      end
      checks++;
      if (rise_o !== 13'h0104 || fall_o !== 13'h0) begin
         errors++;
         $display("FAIL simul_rise got %h/%h want 0104/0", rise_o, fall_o);
      end
   endtask

   task automatic test_irq();
      int cyc;
      step();
      irq_clr = 1'b1;
      step();
      irq_clr = 1'b0;
      checks++;
      if (irq_o !== 1'b0) begin
         errors++;
         $display("FAIL irq_clr0 got %b want 0", irq_o);
      end
      sw_i = 13'h0106;
      wait_sw(13'h0106, 14, cyc);
      checks++;
      if (cyc > 14 || rise_o !== 13'h0002) begin
         errors++;
         $display("FAIL irq_press got %0d/%h want <=14/0002", cyc, rise_o);
      end
      step();
      checks++;
      if (irq_o !== IrqEn) begin
         errors++;
         $display("FAIL irq_set got %b want %b", irq_o, IrqEn);
      end
      irq_clr = 1'b1;
      step();
      irq_clr = 1'b0;
      checks++;
      if (irq_o !== 1'b0) begin
         errors++;
         $display("FAIL irq_lone_clr got %b want 0", irq_o);
      end
      sw_i = 13'h0104;
      wait_sw(13'h0104, 14, cyc);
      checks++;
      if (cyc > 14 || fall_o !== 13'h0002) begin
         errors++;
         $display("FAIL irq_fall got %0d/%h want <=14/0002", cyc, fall_o);
      end
      irq_clr = 1'b1;
      step();
      irq_clr = 1'b0;
      checks++;
      if (irq_o !== IrqEn) begin
         errors++;
         $display("FAIL irq_set_wins got %b want %b", irq_o, IrqEn);
      end
      irq_clr = 1'b1;
      step();
      irq_clr = 1'b0;
      checks++;
      if (irq_o !== 1'b0) begin
         errors++;
         $display("FAIL irq_final_clr got %b want 0", irq_o);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_release_all();
      test_clean_press();
      test_bounce();
      test_release();
      test_simultaneous();
      test_irq();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
